// File: rtl/ttr_vote_stage.sv
// Time-triple-redundancy vote stage: collects three time-redundant samples per frame and majority-votes them.
// Optional saturating mismatch counter is built only when TTR_ERRCNT_EN is defined.
module ttr_vote_stage #(
    parameter int WIDTH = 8,
    parameter int CNTW  = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       ctr,
    input  logic [WIDTH-1:0] din,
    input  logic             clr_err,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    output logic             mis,
    output logic             uncorr,
    output logic             sync_err,
    output logic             ctr_mis,
    output logic [CNTW-1:0]  err_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GOT_A = 2'd1,
        GOT_B = 2'd2
    } state_t;

    function automatic logic [WIDTH-1:0] majority(
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b,
        input logic [WIDTH-1:0] c
    );
        majority = (a & b) | (a & c) | (b & c);
    endfunction

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             mis_q, mis_d;
    logic             uncorr_q, uncorr_d;
    logic             dout_valid_q;
    logic             sync_err_q;
    logic             ctr_mis_q;
    logic             stb;
    logic             frame_done;
    logic             sync_set;

    // Either strobe copy alone keeps framing alive if the other sticks low.
    assign stb = ctr[0] | ctr[1];

    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        frame_done = 1'b0;
        sync_set   = 1'b0;
        if (stb) begin
            a_d      = din;
            state_d  = GOT_A;
            sync_set = (state_q != IDLE);
        end else begin
            case (state_q)
                GOT_A: begin
                    b_d     = din;
                    state_d = GOT_B;
                end
                GOT_B: begin
                    frame_done = 1'b1;
                    state_d    = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        dout_d   = dout_q;
        mis_d    = mis_q;
        uncorr_d = uncorr_q;
        if (frame_done) begin
            dout_d   = majority(a_q, b_q, din);
            mis_d    = (a_q != b_q) | (b_q != din);
            uncorr_d = (a_q != b_q) & (b_q != din) & (a_q != din);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            a_q          <= '0;
            b_q          <= '0;
            dout_q       <= '0;
            mis_q        <= 1'b0;
            uncorr_q     <= 1'b0;
            dout_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            a_q          <= a_d;
            b_q          <= b_d;
            dout_q       <= dout_d;
            mis_q        <= mis_d;
            uncorr_q     <= uncorr_d;
            dout_valid_q <= frame_done;
        end
    end

    // Sticky flags: a set event in the same cycle as clr_err wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_err_q <= 1'b0;
            ctr_mis_q  <= 1'b0;
        end else begin
            if (sync_set) begin
                sync_err_q <= 1'b1;
            end else if (clr_err) begin
                sync_err_q <= 1'b0;
            end
            if (ctr[0] != ctr[1]) begin
                ctr_mis_q <= 1'b1;
            end else if (clr_err) begin
                ctr_mis_q <= 1'b0;
            end
        end
    end

`ifdef TTR_ERRCNT_EN
    function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] cnt);
        sat_inc = (cnt == {CNTW{1'b1}}) ? cnt : cnt + 1'b1;
    endfunction

    logic [CNTW-1:0] err_cnt_q, err_cnt_d;
    logic            cnt_inc;

    // Counts at the edge that publishes the frame, so err_cnt moves with dout_valid.
    assign cnt_inc = frame_done & mis_d;

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (cnt_inc) begin
            err_cnt_d = clr_err ? {{(CNTW-1){1'b0}}, 1'b1} : sat_inc(err_cnt_q);
        end else if (clr_err) begin
            err_cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_cnt = err_cnt_q;
`else
    assign err_cnt = '0;
`endif

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign mis        = mis_q;
    assign uncorr     = uncorr_q;
    assign sync_err   = sync_err_q;
    assign ctr_mis    = ctr_mis_q;

endmodule

// File: tb/tb_ttr_vote_stage.sv
// Directed bench for ttr_vote_stage (CNTW=2 so counter saturation is reachable).
// Expected err_cnt values follow TTR_ERRCNT_EN: counts when defined, constant 0 otherwise.
module tb_ttr_vote_stage;

    localparam int WIDTH = 8;
    localparam int CNTW  = 2;
`ifdef TTR_ERRCNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic             clk;
    logic             reset;
    logic [1:0]       ctr;
    logic [WIDTH-1:0] din;
    logic             clr_err;
    logic [WIDTH-1:0] dout;
    logic             dout_valid;
    logic             mis;
    logic             uncorr;
    logic             sync_err;
    logic             ctr_mis;
    logic [CNTW-1:0]  err_cnt;

    int checks = 0;
    int errors = 0;

    ttr_vote_stage #(.WIDTH(WIDTH), .CNTW(CNTW)) dut (
        .clk        (clk),
        .reset      (reset),
        .ctr        (ctr),
        .din        (din),
        .clr_err    (clr_err),
        .dout       (dout),
        .dout_valid (dout_valid),
        .mis        (mis),
        .uncorr     (uncorr),
        .sync_err   (sync_err),
        .ctr_mis    (ctr_mis),
        .err_cnt    (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] ecnt(input int n);
        ecnt = CNT_EN ? n : 0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: apply inputs, take the edge, settle 1 time unit past it.
    task automatic step(input logic [1:0] c, input logic [WIDTH-1:0] d,
                        input logic cl, input logic r);
        ctr     = c;
        din     = d;
        clr_err = cl;
        reset   = r;
        @(posedge clk);
        #1;
    endtask

    task automatic frame(input logic [1:0] c, input logic [WIDTH-1:0] a,
                         input logic [WIDTH-1:0] b, input logic [WIDTH-1:0] cc);
        step(c, a, 1'b0, 1'b0);
        step(2'b00, b, 1'b0, 1'b0);
        step(2'b00, cc, 1'b0, 1'b0);
    endtask

    initial begin
        ctr = 2'b00; din = '0; clr_err = 1'b0; reset = 1'b1;

        // Reset with strobes and ctr mismatch active: all ignored.
        step(2'b01, 8'hFF, 1'b1, 1'b1);
        step(2'b11, 8'hFF, 1'b0, 1'b1);
        chk("rst_dout", dout, 8'h00);
        chk("rst_valid", dout_valid, 1'b0);
        chk("rst_mis", mis, 1'b0);
        chk("rst_uncorr", uncorr, 1'b0);
        chk("rst_sync_err", sync_err, 1'b0);
        chk("rst_ctr_mis", ctr_mis, 1'b0);
        chk("rst_err_cnt", err_cnt, 32'd0);

        // Clean frame.
        step(2'b11, 8'h5A, 1'b0, 1'b0);
        chk("clean_valid_c1", dout_valid, 1'b0);
        step(2'b00, 8'h5A, 1'b0, 1'b0);
        chk("clean_valid_c2", dout_valid, 1'b0);
        step(2'b00, 8'h5A, 1'b0, 1'b0);
        chk("clean_valid_c3", dout_valid, 1'b1);
        chk("clean_dout", dout, 8'h5A);
        chk("clean_mis", mis, 1'b0);
        chk("clean_uncorr", uncorr, 1'b0);
        step(2'b00, 8'hEE, 1'b0, 1'b0);
        chk("clean_pulse_end", dout_valid, 1'b0);
        chk("clean_hold", dout, 8'h5A);

        // Single upset, immediately followed back-to-back by a triple disagreement.
        frame(2'b11, 8'h5A, 8'h5B, 8'h5A);
        chk("upset_valid", dout_valid, 1'b1);
        chk("upset_dout", dout, 8'h5A);
        chk("upset_mis", mis, 1'b1);
        chk("upset_uncorr", uncorr, 1'b0);
        chk("upset_err_cnt", err_cnt, ecnt(1));
        frame(2'b11, 8'h01, 8'h02, 8'h04);
        chk("triple_dout", dout, 8'h00);
        chk("triple_mis", mis, 1'b1);
        chk("triple_uncorr", uncorr, 1'b1);
        chk("b2b_sync_err", sync_err, 1'b0);
        chk("triple_err_cnt", err_cnt, ecnt(2));

        // Early strobe while in GOT_A.
        step(2'b11, 8'hAA, 1'b0, 1'b0);
        step(2'b11, 8'h33, 1'b0, 1'b0);
        chk("early_sync_err", sync_err, 1'b1);
        chk("early_valid1", dout_valid, 1'b0);
        step(2'b00, 8'h33, 1'b0, 1'b0);
        chk("early_valid2", dout_valid, 1'b0);
        step(2'b00, 8'h33, 1'b0, 1'b0);
        chk("early_valid3", dout_valid, 1'b1);
        chk("early_dout", dout, 8'h33);
        chk("early_mis", mis, 1'b0);

        // clr_err clears sticky state but leaves the datapath alone.
        step(2'b00, 8'h00, 1'b1, 1'b0);
        chk("clr_sync_err", sync_err, 1'b0);
        chk("clr_err_cnt", err_cnt, 32'd0);
        chk("clr_dout_hold", dout, 8'h33);
        chk("clr_mis_hold", mis, 1'b0);

        // ctr[1] stuck low: frames still vote via ctr[0]; five mis frames saturate the 2-bit counter.
        frame(2'b01, 8'h7E, 8'h7E, 8'h7F);
        chk("stuck_valid", dout_valid, 1'b1);
        chk("stuck_dout", dout, 8'h7E);
        chk("stuck_ctr_mis", ctr_mis, 1'b1);
        chk("stuck_err_cnt", err_cnt, ecnt(1));
        for (int i = 0; i < 4; i++) begin
            frame(2'b01, 8'h0F, 8'hF0, 8'h0F);
        end
        chk("sat_dout", dout, 8'h0F);
        chk("sat_err_cnt", err_cnt, ecnt(3));

        // Set wins over simultaneous clear.
        step(2'b10, 8'h11, 1'b1, 1'b0);
        chk("setwin_ctr_mis", ctr_mis, 1'b1);
        chk("setwin_err_cnt_clr", err_cnt, 32'd0);
        step(2'b00, 8'h11, 1'b0, 1'b0);
        step(2'b00, 8'h10, 1'b1, 1'b0);
        chk("setwin_dout", dout, 8'h11);
        chk("setwin_mis", mis, 1'b1);
        chk("setwin_err_cnt", err_cnt, ecnt(1));
        chk("setwin_ctr_mis_clr", ctr_mis, 1'b0);

        // Reset in GOT_B drops the frame.
        step(2'b11, 8'hC3, 1'b0, 1'b0);
        step(2'b00, 8'hC3, 1'b0, 1'b0);
        step(2'b00, 8'hC3, 1'b0, 1'b1);
        chk("midrst_valid", dout_valid, 1'b0);
        chk("midrst_dout", dout, 8'h00);
        chk("midrst_mis", mis, 1'b0);
        chk("midrst_sync_err", sync_err, 1'b0);
        chk("midrst_err_cnt", err_cnt, 32'd0);
        step(2'b00, 8'hC3, 1'b0, 1'b0);
        chk("midrst_idle_valid", dout_valid, 1'b0);
        frame(2'b11, 8'h3C, 8'h3C, 8'h3C);
        chk("post_rst_valid", dout_valid, 1'b1);
        chk("post_rst_dout", dout, 8'h3C);
        chk("post_rst_mis", mis, 1'b0);
        chk("post_rst_sync_err", sync_err, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ttr_vote_stage.md
TTR_VOTE_STAGE -- requirements
Module: ttr_vote_stage

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, the data word width in bits.
REQ-002 The block SHALL have parameter CNTW, default 8, the error-counter width in bits.
REQ-003 The block SHALL have port clk, input, 1 bit, the single global synchronous clock; all state SHALL change on its rising edge only.
REQ-004 The block SHALL have port reset, input, 1 bit, a synchronous active-high reset.
REQ-005 The block SHALL have port ctr, input, 2 bits, redundant frame-start strobes from the TTR phase counter; each bit is high for one cycle in three.
REQ-006 The block SHALL have port din, input, WIDTH bits, the time-triplicated data, presented as the same word on three consecutive cycles.
REQ-007 The block SHALL have port clr_err, input, 1 bit, which clears the sticky flags and err_cnt.
REQ-008 The block SHALL have port dout, output, WIDTH bits, the voted word.
REQ-009 The block SHALL have port dout_valid, output, 1 bit, a one-cycle pulse qualifying dout.
REQ-010 The block SHALL have port mis, output, 1 bit, set when not all three samples of a frame were equal; valid with dout_valid.
REQ-011 The block SHALL have port uncorr, output, 1 bit, set when no two samples of a frame were equal; valid with dout_valid.
REQ-012 The block SHALL have port sync_err, output, 1 bit, a sticky flag for an aborted frame.
REQ-013 The block SHALL have port ctr_mis, output, 1 bit, a sticky flag for ctr[0] != ctr[1].
REQ-014 The block SHALL have port err_cnt, output, CNTW bits, a saturating count of frames with mis=1.

Function
REQ-015 The frame strobe SHALL be stb = ctr[0] | ctr[1], so that a single stuck-low strobe bit does not lose framing.
REQ-016 The FSM SHALL have the states IDLE, GOT_A and GOT_B.
REQ-017 In any state with stb=1, the block SHALL capture din into sample A and go to GOT_A.
REQ-018 In GOT_A with stb=0, the block SHALL capture din into sample B and go to GOT_B.
REQ-019 In GOT_B with stb=0, the block SHALL take din as sample C, register the outputs and go to IDLE.
REQ-020 In IDLE with stb=0, the block SHALL hold state and capture nothing.
REQ-021 On the GOT_B->IDLE transition, the registered outputs SHALL be as follows:
- dout = bitwise majority (A&B)|(A&C)|(B&C);
- dout_valid = 1 for exactly one cycle, the cycle after C is sampled (latency 3 cycles from A);
- mis = (A!=B)|(B!=C);
- uncorr = (A!=B)&(B!=C)&(A!=C).
REQ-022 dout, mis and uncorr SHALL hold their values until the next frame completes.
REQ-023 stb=1 in GOT_A or GOT_B (early strobe) SHALL discard the partial frame, emit no dout_valid, set sync_err and restart at GOT_A.
REQ-024 stb=1 in the cycle after C is sampled (the normal back-to-back case) SHALL NOT set sync_err.
REQ-025 Any cycle with ctr[0] != ctr[1] SHALL set ctr_mis.
REQ-026 err_cnt SHALL increment by 1 on each dout_valid with mis=1 and SHALL saturate at 2^CNTW-1 without wrapping.
REQ-027 clr_err=1 SHALL clear sync_err, ctr_mis and err_cnt next cycle.
REQ-028 When clr_err and a set event occur in the same cycle, the set SHALL win: the flag reads 1 and err_cnt reads 1.
REQ-029 clr_err SHALL NOT affect the FSM, dout, dout_valid, mis or uncorr.

Reset
REQ-030 reset=1 at a clock edge SHALL force state to IDLE and clear sample registers A and B, dout, dout_valid, mis, uncorr, sync_err, ctr_mis and err_cnt.
REQ-031 Reset SHALL take priority over stb and clr_err.
REQ-032 Reset asserted mid-frame SHALL drop the partial frame, with no dout_valid and no sync_err.
REQ-033 While reset=1, strobes SHALL be ignored.
REQ-034 The first stb after reset deasserts SHALL start a frame normally.

Configuration
REQ-035 With macro TTR_ERRCNT_EN defined, err_cnt SHALL behave per REQ-026 to REQ-028.
REQ-036 With TTR_ERRCNT_EN undefined, the err_cnt port SHALL remain present and be driven constant 0, and no counter logic SHALL be synthesised.
REQ-037 All other behaviour SHALL be identical with and without TTR_ERRCNT_EN.

Verification
REQ-038 The bench SHALL cover a clean frame: din=8'h5A for 3 cycles from stb -> dout=8'h5A, dout_valid pulse 3 cycles after stb, mis=0, uncorr=0.
REQ-039 The bench SHALL cover a single upset: samples 8'h5A, 8'h5B, 8'h5A -> dout=8'h5A, mis=1, uncorr=0, err_cnt=1.
REQ-040 The bench SHALL cover a triple disagreement: samples 8'h01, 8'h02, 8'h04 -> dout=8'h00, mis=1, uncorr=1.
REQ-041 The bench SHALL cover an early strobe: stb in GOT_A -> no dout_valid, sync_err=1; the frame from the second stb completes 3 cycles later.
REQ-042 The bench SHALL cover strobe fault and saturation: ctr[1] held 0 -> frames still vote via ctr[0], ctr_mis=1; with CNTW=2, five mis frames -> err_cnt=3.
REQ-043 The bench SHALL cover reset mid-frame: reset in GOT_B -> outputs 0, no dout_valid, and the next stb frame is correct.
